// File: rtl/imem_fetch_port_if.sv
// Fetch-side handshake bundle for imem_fetch_port.
//   master : fetch stage (drives req_valid/req_pc, rsp_ready)
//   slave  : instruction memory (drives req_ready, rsp_valid/inst/pc/fault)
interface imem_fetch_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic [ADDR_W-1:0] rsp_pc;
  logic [1:0]        rsp_fault;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault
  );
endinterface

// File: rtl/imem_fetch_port.sv
// Registered instruction memory for the fetch stage.
// A request (pc) is accepted through a valid/ready handshake and answered one
// cycle later from a single-entry output register. Byte addresses are decoded
// to word indices with misaligned (01) and out-of-range (10) faults; faulted
// responses carry a NOP (0). A write port loads program words, and flush drops
// the held response.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         req_valid/req_ready/req_pc, rsp_valid/rsp_ready/
//                       rsp_inst/rsp_pc/rsp_fault
//   flush               discard held response, block acceptance this cycle
//   prog_we/addr/data   program-load write port (word indexed)
module imem_fetch_port #(
  parameter int    ADDR_W    = 32,
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 64,
  parameter string INIT_FILE = "",
  parameter int    IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_fetch_port_if.slave  bus,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] word_full;
  logic              misaligned;
  logic              out_of_range;
  logic [1:0]        fault_nxt;
  logic [DATA_W-1:0] inst_nxt;

  // The memory starts as NOPs.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Readiness depends only on the output slot and flush, never on req_valid.
  assign bus.req_ready = !flush && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // Range check uses the whole shifted pc so high address bits cannot alias
  // back into the array.
  assign word_full    = bus.req_pc >> 2;
  assign rd_idx       = bus.req_pc[IDX_W+1:2];
  assign misaligned   = (bus.req_pc[1:0] != 2'b00);
  assign out_of_range = (word_full >= ADDR_W'(DEPTH));

  always_comb begin
    fault_nxt = 2'b00;
    inst_nxt  = '0;
    if (misaligned) begin
      fault_nxt = 2'b01;
    end else if (out_of_range) begin
      fault_nxt = 2'b10;
    end else begin
      inst_nxt = mem[rd_idx];
    end
  end

  // The read above samples mem before this edge's write lands, so a same-cycle
  // write to the fetched index returns the old word.
  always_ff @(posedge clk) begin
    if (rst_n && prog_we && (32'(prog_addr) < 32'(DEPTH))) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_inst  <= '0;
      bus.rsp_pc    <= '0;
      bus.rsp_fault <= 2'b00;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_inst  <= inst_nxt;
      bus.rsp_pc    <= bus.req_pc;
      bus.rsp_fault <= fault_nxt;
    end else if (flush || bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;

  logic        clk;
  logic        rst_n;
  logic        flush_a, prog_we_a;
  logic [5:0]  prog_addr_a;
  logic [31:0] prog_data_a;
  logic        flush_b, prog_we_b;
  logic [5:0]  prog_addr_b;
  logic [31:0] prog_data_b;

  imem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  imem_fetch_port_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  imem_fetch_port #(.ADDR_W(32), .DATA_W(32), .DEPTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .flush(flush_a),
    .prog_we(prog_we_a), .prog_addr(prog_addr_a), .prog_data(prog_data_a)
  );

  imem_fetch_port #(.ADDR_W(32), .DATA_W(32), .DEPTH(48)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .flush(flush_b),
    .prog_we(prog_we_b), .prog_addr(prog_addr_b), .prog_data(prog_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state for dut_a: program image plus the one held response
  logic [31:0] ref_mem [64];
  logic        exp_v;
  logic [31:0] exp_inst, exp_pc;
  logic [1:0]  exp_fault;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of dut_a traffic, checked against the reference.
  task automatic step(input logic rv, input logic [31:0] pc, input logic rr,
                      input logic fl, input logic we, input logic [5:0] wa,
                      input logic [31:0] wd, input logic rn);
    logic        exp_ready, acc;
    logic [31:0] widx;
    bus_a.req_valid = rv;
    bus_a.req_pc    = pc;
    bus_a.rsp_ready = rr;
    flush_a         = fl;
    prog_we_a       = we;
    prog_addr_a     = wa;
    prog_data_a     = wd;
    rst_n           = rn;
    #1;
    exp_ready = !fl && (!exp_v || rr);
    chk_eq("req_ready", {63'd0, bus_a.req_ready}, {63'd0, exp_ready});
    acc = rv && exp_ready;
    @(posedge clk);
    if (!rn) begin
      exp_v = 1'b0; exp_inst = '0; exp_pc = '0; exp_fault = 2'b00;
    end else if (acc) begin
      widx   = pc / 4;
      exp_v  = 1'b1;
      exp_pc = pc;
      if (pc % 4 != 0)    exp_fault = 2'b01;
      else if (widx >= 64) exp_fault = 2'b10;
      else                 exp_fault = 2'b00;
      exp_inst = (exp_fault == 2'b00) ? ref_mem[widx[5:0]] : 32'h0;
    end else if (fl || rr) begin
      exp_v = 1'b0;
    end
    if (rn && we) ref_mem[wa] = wd;
    @(negedge clk);
    chk_eq("rsp_valid", {63'd0, bus_a.rsp_valid}, {63'd0, exp_v});
    if (exp_v || !rn) begin
      chk_eq("rsp_inst",  {32'd0, bus_a.rsp_inst}, {32'd0, exp_inst});
      chk_eq("rsp_pc",    {32'd0, bus_a.rsp_pc},   {32'd0, exp_pc});
      chk_eq("rsp_fault", {62'd0, bus_a.rsp_fault}, {62'd0, exp_fault});
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1'b1, pc, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
  endtask

  task automatic prog(input logic [5:0] wa, input logic [31:0] wd);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, wa, wd, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    bus_a.req_valid = 0; bus_a.req_pc = 0; bus_a.rsp_ready = 1;
    bus_b.req_valid = 0; bus_b.req_pc = 0; bus_b.rsp_ready = 1;
    flush_a = 0; prog_we_a = 0; prog_addr_a = 0; prog_data_a = 0;
    flush_b = 0; prog_we_b = 0; prog_addr_b = 0; prog_data_b = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_v = 0; exp_inst = 0; exp_pc = 0; exp_fault = 0;
    chk_eq("reset_valid", {63'd0, bus_a.rsp_valid}, 64'd0);
    chk_eq("reset_inst",  {32'd0, bus_a.rsp_inst},  64'd0);
    chk_eq("reset_pc",    {32'd0, bus_a.rsp_pc},    64'd0);
    chk_eq("reset_fault", {62'd0, bus_a.rsp_fault}, 64'd0);

    // program load, then back-to-back fetches
    prog(6'd0, 32'h20100001);
    prog(6'd1, 32'h00102020);
    prog(6'd2, 32'h0c00000a);
    fetch(32'h0); chk_eq("t1_w0", {32'd0, bus_a.rsp_inst}, 64'h20100001);
    fetch(32'h4); chk_eq("t1_w1", {32'd0, bus_a.rsp_inst}, 64'h00102020);
    fetch(32'h8); chk_eq("t1_w2", {32'd0, bus_a.rsp_inst}, 64'h0c00000a);
    idle();

    // stall holds the response and blocks the next request
    fetch(32'h4);
    repeat (3) begin
      step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
      chk_eq("t2_hold_inst", {32'd0, bus_a.rsp_inst}, 64'h00102020);
      chk_eq("t2_hold_pc",   {32'd0, bus_a.rsp_pc},   64'h4);
    end
    fetch(32'h8); chk_eq("t2_release", {32'd0, bus_a.rsp_inst}, 64'h0c00000a);

    // faults and their priority
    fetch(32'h6);        chk_eq("t3_misalign", {62'd0, bus_a.rsp_fault}, 64'd1);
    fetch(32'h100);      chk_eq("t3_range",    {62'd0, bus_a.rsp_fault}, 64'd2);
    fetch(32'h102);      chk_eq("t3_prio",     {62'd0, bus_a.rsp_fault}, 64'd1);
    fetch(32'h8000_0008); chk_eq("t3_upper",   {62'd0, bus_a.rsp_fault}, 64'd2);

    // read-first on same-cycle write
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 6'd2, 32'hdeadbeef, 1'b1);
    chk_eq("t4_old", {32'd0, bus_a.rsp_inst}, 64'h0c00000a);
    fetch(32'h8); chk_eq("t4_new", {32'd0, bus_a.rsp_inst}, 64'hdeadbeef);

    // flush during a stall
    fetch(32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0, 1'b1);
    chk_eq("t5_flushed", {63'd0, bus_a.rsp_valid}, 64'd0);
    idle();
    chk_eq("t5_not_taken", {63'd0, bus_a.rsp_valid}, 64'd0);

    // reset during a stall keeps program words
    fetch(32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0);
    chk_eq("t6_rst_valid", {63'd0, bus_a.rsp_valid}, 64'd0);
    chk_eq("t6_rst_inst",  {32'd0, bus_a.rsp_inst},  64'd0);
    chk_eq("t6_rst_fault", {62'd0, bus_a.rsp_fault}, 64'd0);
    fetch(32'h8); chk_eq("t6_survive", {32'd0, bus_a.rsp_inst}, 64'hdeadbeef);
    idle();

    // DEPTH=48 instance
    prog_we_b = 1; prog_addr_b = 6'd47; prog_data_b = 32'h47474747;
    @(posedge clk); #1;
    prog_we_b = 0; bus_b.req_valid = 1; bus_b.req_pc = 32'hBC;
    @(posedge clk); #1;
    chk_eq("b_bc_valid", {63'd0, bus_b.rsp_valid}, 64'd1);
    chk_eq("b_bc_inst",  {32'd0, bus_b.rsp_inst},  64'h47474747);
    chk_eq("b_bc_fault", {62'd0, bus_b.rsp_fault}, 64'd0);
    bus_b.req_pc = 32'hC0;
    @(posedge clk); #1;
    chk_eq("b_c0_fault", {62'd0, bus_b.rsp_fault}, 64'd2);
    chk_eq("b_c0_inst",  {32'd0, bus_b.rsp_inst},  64'd0);
    chk_eq("b_c0_pc",    {32'd0, bus_b.rsp_pc},    64'hC0);
    bus_b.req_valid = 0; prog_we_b = 1; prog_addr_b = 6'd50; prog_data_b = 32'hffffffff;
    @(posedge clk); #1;
    prog_we_b = 0; bus_b.req_valid = 1; bus_b.req_pc = 32'h8;
    @(posedge clk); #1;
    chk_eq("b_drop_inst",  {32'd0, bus_b.rsp_inst},  64'd0);
    chk_eq("b_drop_fault", {62'd0, bus_b.rsp_fault}, 64'd0);
    bus_b.req_valid = 0;
    @(negedge clk);

    // randomized traffic on dut_a
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] pc;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel <= 7) pc = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 8) pc = 32'($urandom_range(64, 1023)) << 2;
      else               pc = $urandom;
      step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 49) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
